// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: opcode and func3 encodings, FSM state type,
// and the alignment/byte-enable helpers used when an access is accepted.
package memory_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_RESP} mem_state_e;

  // Unknown func3 codes report as not ok, so they take the misaligned path.
  function automatic logic access_ok(input logic is_store, input logic [2:0] func3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (func3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~off[0];
        F3_SW:   ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (func3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~off[0];
        F3_LW:         ok = (off == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] func3, input logic [1:0] off);
    logic [3:0] s;
    case (func3)
      F3_SB:   s = 4'b0001 << off;
      F3_SH:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/memory_stage_load_formatter.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module load_formatter
  import memory_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (func3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results through, performs loads/stores over a
// req/gnt/rvalid port, and stalls upstream while an access is outstanding.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   valE,
  input  logic [XLEN-1:0]   valB,
  output logic              stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   valM,
  output logic              misaligned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output mem_state_e        dbg_state
);

  // Handshake: dmem_req/we/addr/wdata/wstrb are held stable from entry into REQ until
  // the cycle dmem_gnt is seen high; read data is taken on the first dmem_rvalid in RESP.
  // Upstream treats any cycle with stall=0 as the one where its inputs are consumed.

  generate
    if (XLEN != 32) begin : g_xlen_check
      $error("memory_stage: byte-lane logic is defined for XLEN=32 only");
    end
  endgenerate

  mem_state_e      state, state_nx;
  logic            is_load, is_store, is_mem, aligned;
  logic [1:0]      off_q;
  logic [2:0]      func3_q;
  logic [XLEN-1:0] load_val;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_mem    = is_load | is_store;
  assign aligned   = access_ok(is_store, func3, valE[1:0]);
  assign dmem_req  = (state == MEM_REQ);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (in_valid && is_mem && aligned) begin
          stall    = 1'b1;
          state_nx = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (dmem_gnt) begin
          state_nx = dmem_we ? MEM_IDLE : MEM_RESP;
          stall    = ~dmem_we;
        end else begin
          stall = 1'b1;
        end
      end
      MEM_RESP: begin
        if (dmem_rvalid) state_nx = MEM_IDLE;
        else             stall    = 1'b1;
      end
      default: state_nx = MEM_IDLE;
    endcase
  end

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .func3  (func3_q),
    .result (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      valM       <= '0;
      misaligned <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      off_q      <= 2'b00;
      func3_q    <= 3'b000;
    end else begin
      out_valid <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              out_valid  <= 1'b1;
              valM       <= valE;
              misaligned <= 1'b0;
            end else if (!aligned) begin
              out_valid  <= 1'b1;
              valM       <= '0;
              misaligned <= 1'b1;
            end else begin
              dmem_addr  <= {valE[XLEN-1:2], 2'b00};
              dmem_we    <= is_store;
              dmem_wstrb <= is_store ? store_strb(func3, valE[1:0]) : '0;
              dmem_wdata <= valB << {valE[1:0], 3'b000};
              off_q      <= valE[1:0];
              func3_q    <= func3;
            end
          end
        end
        MEM_REQ: begin
          if (dmem_gnt && dmem_we) begin
            out_valid  <= 1'b1;
            valM       <= '0;
            misaligned <= 1'b0;
          end
        end
        MEM_RESP: begin
          if (dmem_rvalid) begin
            out_valid  <= 1'b1;
            valM       <= load_val;
            misaligned <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
